// File: rtl/buffet_pkg.sv
// buffet_pkg: shared definitions for the buffet controller slice.
//   rd_state_e  read-side FSM encoding (also visible on RD_STATE)
//   STATS_W     width of the optional stall counters
//   sat_inc     saturating increment for the stall counters
package buffet_pkg;

   typedef enum logic [1:0] {
      RD_IDLE        = 2'd0,
      RD_STALL_EMPTY = 2'd1,
      RD_STALL_OUT   = 2'd2
   } rd_state_e;

   localparam int STATS_W = 32;

   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (&v) ? v : v + STATS_W'(1);
   endfunction

endpackage

// File: rtl/buffet_ctrl_if.sv
// buffet_ctrl_if: producer/consumer handshakes, RAM-side strobes and status
// of the buffet controller.
//   slave  : controller side (buffet_ctrl)
//   master : environment side (producer, consumer, RAM)
// With BUFFET_CTRL_STATS_EN defined the two stall counters are added.
interface buffet_ctrl_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
);
   logic                  FVALID;
   logic [DATA_WIDTH-1:0] FDATA;
   logic                  FREADY;
   logic [ADDR_WIDTH-1:0] RIDX;
   logic                  RIDX_VALID;
   logic                  RIDX_READY;
   logic [ADDR_WIDTH:0]   SHRINK_NUM;
   logic                  SHRINK_VALID;
   logic                  SHRINK_READY;
   logic [ADDR_WIDTH-1:0] WADDR0;
   logic                  WVALID0;
   logic [DATA_WIDTH-1:0] WDATA0;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  MEM_RVALID;
   logic                  RREADY;
   logic [ADDR_WIDTH:0]   OCCUPANCY;
   logic [1:0]            RD_STATE;
`ifdef BUFFET_CTRL_STATS_EN
   logic [31:0]           STALL_EMPTY_CNT;
   logic [31:0]           STALL_OUT_CNT;
`endif

   modport slave (
      input  FVALID, FDATA, RIDX, RIDX_VALID, SHRINK_NUM, SHRINK_VALID,
             MEM_RVALID, RREADY,
      output FREADY, RIDX_READY, SHRINK_READY, WADDR0, WVALID0, WDATA0,
             ARADDR, ARVALID, OCCUPANCY, RD_STATE
`ifdef BUFFET_CTRL_STATS_EN
      , output STALL_EMPTY_CNT, STALL_OUT_CNT
`endif
   );

   modport master (
      output FVALID, FDATA, RIDX, RIDX_VALID, SHRINK_NUM, SHRINK_VALID,
             MEM_RVALID, RREADY,
      input  FREADY, RIDX_READY, SHRINK_READY, WADDR0, WVALID0, WDATA0,
             ARADDR, ARVALID, OCCUPANCY, RD_STATE
`ifdef BUFFET_CTRL_STATS_EN
      , input STALL_EMPTY_CNT, STALL_OUT_CNT
`endif
   );

endinterface

// File: rtl/buffet_ptr.sv
// buffet_ptr: ADDR_WIDTH+1 bit wrap pointer for the buffet. The extra top bit
// is the wrap bit that separates full from empty.
//   CLK, RESET  clock, async active-low reset (pointer clears to 0)
//   inc_en_i    add inc_num_i this cycle
//   inc_num_i   increment amount
//   ptr_o       current pointer value
module buffet_ptr
   import buffet_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                inc_en_i,
   input  logic [ADDR_WIDTH:0] inc_num_i,
   output logic [ADDR_WIDTH:0] ptr_o
);

   logic [ADDR_WIDTH:0] ptr_q;
   logic [ADDR_WIDTH:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc_en_i) ptr_d = ptr_q + inc_num_i;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/buffet_ctrl.sv
// buffet_ctrl: pointer and handshake controller in front of dpram_r2.
//   CLK, RESET  clock, async active-low reset
//   bus.slave   fill (FVALID/FDATA/FREADY), read index (RIDX*), shrink
//               (SHRINK_*), RAM write (WADDR0/WVALID0/WDATA0), RAM read
//               (ARADDR/ARVALID), RAM/consumer status (MEM_RVALID/RREADY),
//               OCCUPANCY and RD_STATE
// Optional: BUFFET_CTRL_STATS_EN adds STALL_EMPTY_CNT / STALL_OUT_CNT.
//
// Read FSM
//   state          | meaning
//   RD_IDLE        | no read request, or request accepted this cycle
//   RD_STALL_EMPTY | requested index not filled yet (RIDX >= occ)
//   RD_STALL_OUT   | index filled but RAM output slot still held
module buffet_ctrl
   import buffet_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
) (
   input  logic          CLK,
   input  logic          RESET,
   buffet_ctrl_if.slave  bus
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] SIZE_P = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [PW-1:0] head_q, tail_q, occ;
   logic          slot_free, ridx_in_range;
   logic          fready, ridx_ready, shrink_ready;
   logic          fill_hs, rd_hs, shr_hs;
   rd_state_e     rd_state_q, rd_state_d;

   buffet_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_tail (
      .CLK       (CLK),
      .RESET     (RESET),
      .inc_en_i  (fill_hs),
      .inc_num_i (PW'(1)),
      .ptr_o     (tail_q)
   );

   buffet_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_head (
      .CLK       (CLK),
      .RESET     (RESET),
      .inc_en_i  (shr_hs),
      .inc_num_i (bus.SHRINK_NUM),
      .ptr_o     (head_q)
   );

   // modulo 2**PW difference; the wrap bit makes occ=SIZE distinguishable from 0
   assign occ           = tail_q - head_q;
   assign slot_free     = !bus.MEM_RVALID || bus.RREADY;
   assign ridx_in_range = {1'b0, bus.RIDX} < occ;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) rd_state_q <= RD_IDLE;
      else        rd_state_q <= rd_state_d;
   end

   always_comb begin
      rd_state_d = RD_IDLE;
      if (bus.RIDX_VALID) begin
         if (!ridx_in_range)  rd_state_d = RD_STALL_EMPTY;
         else if (!slot_free) rd_state_d = RD_STALL_OUT;
      end
   end

   // Handshakes all use the pre-update head/tail, so a same-cycle fill cannot
   // make its own entry readable and a same-cycle shrink cannot unblock a fill.
   always_comb begin
      fready       = occ < SIZE_P;
      ridx_ready   = ridx_in_range && slot_free;
      shrink_ready = bus.SHRINK_NUM <= occ;
      fill_hs      = bus.FVALID && fready;
      rd_hs        = bus.RIDX_VALID && ridx_ready;
      shr_hs       = bus.SHRINK_VALID && shrink_ready;
   end

   assign bus.FREADY       = fready;
   assign bus.RIDX_READY   = ridx_ready;
   assign bus.SHRINK_READY = shrink_ready;
   assign bus.WVALID0      = fill_hs;
   assign bus.WADDR0       = tail_q[ADDR_WIDTH-1:0];
   assign bus.WDATA0       = bus.FDATA;
   assign bus.ARVALID      = rd_hs;
   assign bus.ARADDR       = head_q[ADDR_WIDTH-1:0] + bus.RIDX;
   assign bus.OCCUPANCY    = occ;
   assign bus.RD_STATE     = rd_state_q;

`ifdef BUFFET_CTRL_STATS_EN
   logic [STATS_W-1:0] stall_empty_cnt_q, stall_out_cnt_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         stall_empty_cnt_q <= '0;
         stall_out_cnt_q   <= '0;
      end else begin
         if (rd_state_q == RD_STALL_EMPTY) stall_empty_cnt_q <= sat_inc(stall_empty_cnt_q);
         if (rd_state_q == RD_STALL_OUT)   stall_out_cnt_q   <= sat_inc(stall_out_cnt_q);
      end
   end

   assign bus.STALL_EMPTY_CNT = stall_empty_cnt_q;
   assign bus.STALL_OUT_CNT   = stall_out_cnt_q;
`endif

endmodule
